topk_sort_ctrl: RTL and testbench

//  Row scheduler for the insert-sort top-K engine. Streams one row of scored elements into the sorter.

---
 rtl/topk_pkg.sv | 35 +++
 rtl/topk_sort_ctrl.sv | 171 +++++++++++++++++
 tb/tb_topk_sort_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/topk_pkg.sv
// Shared constants, FSM state type and width helpers for the top-K row scheduler.
package topk_pkg;

    localparam int K_NUMBER_DEF     = 32;
    localparam int BLOCK_NUMBER_DEF = 16;
    localparam int LOG2_WIDTH_DEF   = 5;
    localparam int DATA_WIDTH_DEF   = 4;
    localparam int INDEX_WIDTH_DEF  = 9;
    localparam int ROW_W_DEF        = 16;

    localparam int ROW_LEN   = BLOCK_NUMBER_DEF << LOG2_WIDTH_DEF;
    localparam int DRAIN_MAX = K_NUMBER_DEF + 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_e;

    function automatic int row_len(input int blocks, input int log2w);
        return blocks << log2w;
    endfunction

    function automatic int drain_max(input int k);
        return k + 4;
    endfunction

    // The element index must address exactly one row.
    function automatic bit index_w_ok(input int idx_w, input int row_len_v);
        return idx_w == $clog2(row_len_v);
    endfunction

endpackage

// File: rtl/topk_sort_ctrl.sv
// Row scheduler for the insert-sort top-K engine: feeds one row, waits for the sorter, hands off results.
// Optional perf counters are enabled by defining TOPK_CTRL_PERF_EN.
module topk_sort_ctrl
    import topk_pkg::*;
#(
    parameter int K_NUMBER     = K_NUMBER_DEF,
    parameter int BLOCK_NUMBER = BLOCK_NUMBER_DEF,
    parameter int LOG2_WIDTH   = LOG2_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int INDEX_WIDTH  = INDEX_WIDTH_DEF,
    parameter int ROW_W        = ROW_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ROW_W-1:0]       cfg_num_rows,
    output logic                   busy,
    output logic                   done,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_last,
    output logic                   sort_valid,
    output logic [DATA_WIDTH-1:0]  sort_data,
    output logic [INDEX_WIDTH-1:0] sort_index,
    output logic                   sort_clear,
    output logic                   sort_last_block,
    input  logic                   sort_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ROW_W-1:0]       res_row,
`ifdef TOPK_CTRL_PERF_EN
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_res_wait,
`endif
    output logic                   err_len,
    output logic                   err_timeout
);

    localparam int ROW_LEN_P   = row_len(BLOCK_NUMBER, LOG2_WIDTH);
    localparam int DRAIN_MAX_P = drain_max(K_NUMBER);
    localparam int DCNT_W      = (DRAIN_MAX_P > 2) ? $clog2(DRAIN_MAX_P) : 1;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(ROW_LEN_P - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE   = 1;
    localparam logic [DCNT_W-1:0]      DRAIN_END = DCNT_W'(DRAIN_MAX_P - 1);
    localparam logic [DCNT_W-1:0]      DCNT_ONE  = 1;
    localparam logic [ROW_W-1:0]       ROW_ONE   = 1;

    if (!index_w_ok(INDEX_WIDTH, ROW_LEN_P)) begin : g_bad_index_w
        $error("INDEX_WIDTH must equal log2(BLOCK_NUMBER << LOG2_WIDTH)");
    end

    state_e                 state_q;
    logic [INDEX_WIDTH-1:0] elem_cnt_q;
    logic [DCNT_W-1:0]      drain_cnt_q;
    logic [ROW_W-1:0]       row_q;
    logic [ROW_W-1:0]       num_rows_q;
    logic                   done_q;
    logic                   err_len_q;
    logic                   err_timeout_q;
    logic                   hs;
    logic                   at_last;

    assign s_ready         = (state_q == ST_FEED);
    assign hs              = s_valid & s_ready;
    assign at_last         = (elem_cnt_q == LAST_IDX);
    assign sort_valid      = hs;
    assign sort_data       = s_data;
    assign sort_index      = elem_cnt_q;
    assign sort_clear      = (state_q == ST_CLEAR);
    assign sort_last_block = (state_q == ST_DRAIN);
    assign res_valid       = (state_q == ST_RESULT);
    assign res_row         = row_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign err_len         = err_len_q;
    assign err_timeout     = err_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            elem_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            row_q         <= '0;
            num_rows_q    <= '0;
            done_q        <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_rows_q    <= cfg_num_rows;
                        row_q         <= '0;
                        err_len_q     <= 1'b0;
                        err_timeout_q <= 1'b0;
                        if (cfg_num_rows == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    elem_cnt_q <= '0;
                    state_q    <= ST_FEED;
                end
                ST_FEED: begin
                    if (hs) begin
                        // Row length is fixed; s_last only flags disagreement, it never ends the row.
                        if (s_last != at_last) begin
                            err_len_q <= 1'b1;
                        end
                        if (at_last) begin
                            drain_cnt_q <= '0;
                            state_q     <= ST_DRAIN;
                        end else begin
                            elem_cnt_q <= elem_cnt_q + IDX_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_q <= drain_cnt_q + DCNT_ONE;
                    if (sort_done) begin
                        state_q <= ST_RESULT;
                    end else if (drain_cnt_q == DRAIN_END) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        if (row_q == num_rows_q - ROW_ONE) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            row_q   <= row_q + ROW_ONE;
                            state_q <= ST_CLEAR;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef TOPK_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_wait_q;

    always_ff @(posedge clk) begin
        if (rst || (state_q == ST_IDLE && start)) begin
            perf_stall_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            if (state_q == ST_FEED && !s_valid && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (state_q == ST_RESULT && !res_ready && perf_wait_q != '1) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_res_wait     = perf_wait_q;
`endif

endmodule

// File: tb/tb_topk_sort_ctrl.sv
// Self-checking bench for topk_sort_ctrl: table of job vectors plus hand-written reset / zero-row sequences.
module tb_topk_sort_ctrl;

    localparam int RL = 512;
    localparam int DM = 36;

    typedef struct packed {
        logic [8:0] idx;
        logic [3:0] data;
    } elem_t;

    typedef struct {
        int rows;
        int last_pos;
        int done_dly;
        int stall_row;
        int stall_cyc;
        bit poke;
        bit exp_len;
        bit exp_to;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_num_rows;
    logic        busy, done;
    logic        s_valid, s_ready, s_last;
    logic [3:0]  s_data;
    logic        sort_valid;
    logic [3:0]  sort_data;
    logic [8:0]  sort_index;
    logic        sort_clear, sort_last_block, sort_done;
    logic        res_valid, res_ready;
    logic [15:0] res_row;
    logic        err_len, err_timeout;
`ifdef TOPK_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_res_wait;
`endif

    int    errors = 0;
    int    checks = 0;
    int    clear_cnt = 0;
    int    done_cnt = 0;
    elem_t elem_q[$];
    int    res_q[$];
    vec_t  vecs[5];

    always #5 clk = ~clk;

    topk_sort_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_rows(cfg_num_rows),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .sort_valid(sort_valid), .sort_data(sort_data), .sort_index(sort_index),
        .sort_clear(sort_clear), .sort_last_block(sort_last_block), .sort_done(sort_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
`ifdef TOPK_CTRL_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_res_wait(perf_res_wait),
`endif
        .err_len(err_len), .err_timeout(err_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Element scoreboard and event counters.
    always @(negedge clk) begin : mon
        elem_t e;
        if (sort_clear) clear_cnt++;
        if (done) done_cnt++;
        if (sort_valid) begin
            if (elem_q.size() == 0) begin
                chk("sort_valid_unexpected", 32'(sort_index), 32'hFFFF_FFFF);
            end else begin
                e = elem_q.pop_front();
                chk("sort_index", 32'(sort_index), 32'(e.idx));
                chk("sort_data", 32'(sort_data), 32'(e.data));
            end
        end
    end

    task automatic feed_row(input vec_t v, input int r, input int abort_at);
        elem_t e;
        int    n;
        for (int i = 0; i < RL; i++) begin
            if (i == abort_at) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            s_valid = 1'b1;
            s_data  = 4'($urandom);
            s_last  = (i == v.last_pos);
            if (v.poke && r == 0 && i == 50) begin
                start        = 1'b1;
                cfg_num_rows = 16'd5;
            end
            if (v.last_pos < RL - 2 && i == v.last_pos + 2) chk("err_len_early", 32'(err_len), 1);
            e.idx  = 9'(i);
            e.data = s_data;
            elem_q.push_back(e);
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            if (!s_ready) begin
                chk("s_ready", 32'(s_ready), 1);
                elem_q.delete();
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            start        = 1'b0;
            cfg_num_rows = '0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        int c0, d0, cnt, exp_row, stall;
        c0 = clear_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        start        = 1'b1;
        cfg_num_rows = 16'(v.rows);
        for (int r = 0; r < v.rows; r++) res_q.push_back(r);
        @(posedge clk); #1;
        start        = 1'b0;
        cfg_num_rows = '0;
        for (int r = 0; r < v.rows; r++) begin
            @(negedge clk);
            chk("sort_clear", 32'(sort_clear), 1);
            chk("busy", 32'(busy), 1);
            if (r == 0) chk("err_cleared", 32'({err_len, err_timeout}), 0);
            feed_row(v, r, -1);
            cnt = 0;
            while (cnt < DM + 5) begin
                @(negedge clk);
                if (res_valid) break;
                if (cnt == 0) chk("sort_last_block", 32'(sort_last_block), 1);
                sort_done = (cnt == v.done_dly);
                cnt++;
            end
            sort_done = 1'b0;
            chk("res_valid", 32'(res_valid), 1);
            chk("drain_cycles", cnt, (v.done_dly >= 0) ? v.done_dly + 1 : DM);
            exp_row = (res_q.size() != 0) ? res_q.pop_front() : -1;
            chk("res_row", 32'(res_row), exp_row);
            stall = (r == v.stall_row) ? v.stall_cyc : 0;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk("res_hold", 32'({res_valid, res_row}), 32'({1'b1, 16'(exp_row)}));
                chk("no_clear_in_hold", 32'(sort_clear), 0);
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", 32'({done, busy}), 32'(2'b10));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("clear_count", clear_cnt - c0, v.rows);
        chk("done_count", done_cnt - d0, 1);
        chk("err_len", 32'(err_len), 32'(v.exp_len));
        chk("err_timeout", 32'(err_timeout), 32'(v.exp_to));
        chk("elem_q_empty", elem_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : test
        int c0, d0;
        //              rows last done stall_row stall_cyc poke len to
        vecs[0] = '{1, 511, 34, -1, 0,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{3, 511, 3,  1,  10, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1, 100, 5,  -1, 0,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{1, 511, -1, -1, 0,  1'b0, 1'b0, 1'b1};
        vecs[4] = '{2, 511, 0,  0,  2,  1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; cfg_num_rows = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        sort_done = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 32'({busy, done, s_ready, sort_valid, sort_clear, sort_last_block,
                               res_valid, err_len, err_timeout}), 0);
        chk("reset_index_row", 32'({sort_index, res_row}), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        // Zero-row job: done pulse, no clear.
        c0 = clear_cnt;
        @(posedge clk); #1;
        start = 1'b1; cfg_num_rows = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_rows_done", 32'({done, busy, sort_clear}), 32'(3'b100));
        @(negedge clk);
        chk("zero_rows_done_once", 32'(done), 0);
        chk("zero_rows_no_clear", clear_cnt - c0, 0);

        // Reset in the middle of FEED, then a clean job.
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; cfg_num_rows = 16'd1;
        res_q.push_back(0);
        @(posedge clk); #1;
        start = 1'b0; cfg_num_rows = '0;
        @(negedge clk);
        chk("abort_clear", 32'(sort_clear), 1);
        feed_row(vecs[0], 0, 200);
        chk("abort_in_feed", 32'({s_ready, sort_index}), 32'({1'b1, 9'd200}));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ctrl", 32'({busy, done, s_ready, sort_valid, sort_clear, sort_last_block,
                               res_valid, err_len, err_timeout}), 0);
        chk("abort_index_row", 32'({sort_index, res_row}), 0);
        rst = 1'b0;
        res_q.delete();
        chk("abort_elem_q", elem_q.size(), 0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_job(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
